uv_apb_to_bus: RTL and testbench
================================

UV_APB_TO_BUS -- requirements
Module: uv_apb_to_bus

Interface
REQ-001 Parameters SHALL be: ALEN, default 12, address width; DLEN, default 32, data width; MLEN, default DLEN/8, byte-mask width; RSP_TIMEOUT, default 256, response-wait limit in clk cycles (≥2).
REQ-002 Ports SHALL be exactly the following, one per line, as name direction width meaning:
  clk  input  1  single clock; all state on rising edge.
  rst_n  input  1  asynchronous active-low reset.
  apb_psel  input  1  APB select.
  apb_penable  input  1  APB access phase.
  apb_pprot  input  3  APB protection; ignored.
  apb_paddr  input  ALEN  APB address.
  apb_pstrb  input  MLEN  APB write strobes.
  apb_pwrite  input  1  1 = write.
  apb_pwdata  input  DLEN  write data.
  apb_prdata  output  DLEN  read data.
  apb_pready  output  1  transfer complete.
  apb_pslverr  output  1  transfer error.
  bus_req_vld  output  1  bus request valid.
  bus_req_rdy  input  1  bus request ready.
  bus_req_read  output  1  1 = read.
  bus_req_addr  output  ALEN  request address.
  bus_req_mask  output  MLEN  byte mask.
  bus_req_data  output  DLEN  write data.
  bus_rsp_vld  input  1  response valid.
  bus_rsp_rdy  output  1  response ready.
  bus_rsp_excp  input  2  response exception; nonzero = error.
  bus_rsp_data  input  DLEN  response data.

Function
REQ-003 Block SHALL be an APB completer that converts each APB transfer into exactly one bus request/response pair.
REQ-004 FSM SHALL have states IDLE, REQ, RSP, DONE; reset state IDLE.
REQ-005 IDLE: on apb_psel=1 and apb_penable=0 (setup phase) with no drain pending, SHALL register paddr, pwrite, pwdata and mask, then go to REQ.
REQ-006 Registered mask SHALL equal apb_pstrb for writes and all-ones for reads; bus_req_read SHALL equal the inverse of the registered pwrite.
REQ-007 REQ: bus_req_vld SHALL be 1 with stable request fields until bus_req_rdy=1, then go to RSP; vld SHALL never drop before rdy.
REQ-008 RSP: bus_rsp_rdy SHALL be 1; on bus_rsp_vld=1, SHALL capture prdata (bus_rsp_data for reads, zero for writes) and pslverr (bus_rsp_excp≠0), then go to DONE.
REQ-009 DONE: apb_pready SHALL be 1 for exactly one cycle, with prdata/pslverr valid; next state IDLE.
REQ-010 apb_pready SHALL be 0 in all states except DONE; all outputs SHALL be registered.
REQ-011 Minimum latency: setup at cycle T0, bus_req_vld at T1, response accepted at T2, apb_pready at T3.
REQ-012 apb_psel dropping mid-transfer SHALL NOT abort the bus transaction; it completes and pready still pulses once.
REQ-013 prdata and pslverr SHALL hold their values until the next DONE capture.

Reset
REQ-014 On rst_n=0, asynchronously: state IDLE, apb_pready=0, apb_pslverr=0, apb_prdata=0, bus_req_vld=0, bus_rsp_rdy=0, request fields 0, timeout counter 0, drain flag 0.
REQ-015 Reset mid-transfer SHALL discard the transfer without generating pready.

Configuration
REQ-016 Macro UV_APB_TO_BUS_TIMEOUT_EN SHALL enable a response timeout.
REQ-017 With the macro defined, a counter SHALL clear on entering RSP and increment each RSP cycle without bus_rsp_vld; on reaching RSP_TIMEOUT the block SHALL go to DONE with pslverr=1 and prdata=0, and set the drain flag.
REQ-018 While the drain flag is set, bus_rsp_rdy SHALL be 1, and the next bus_rsp_vld SHALL be discarded, clearing the flag; IDLE SHALL not accept a new setup until the flag is clear (the APB requester sees extra wait states).
REQ-019 Timeout SHALL NOT apply in REQ.
REQ-020 Without the macro, RSP SHALL wait indefinitely, and no counter or drain logic SHALL exist.

Verification
REQ-021 Read, addr 0x010, zero-wait bus returning 0xDEADBEEF with excp=0 -> bus_req_read=1 and mask=0xF at T1; pready at T3; prdata=0xDEADBEEF; pslverr=0.
REQ-022 Write, addr 0x004, pstrb=0x3, pwdata=0x12345678, bus_req_rdy delayed 3 cycles -> req fields stable through wait; mask=0x3; pready 3 cycles later than minimum; prdata=0.
REQ-023 Read with excp=2'b01 -> pslverr=1 with pready; the next clean read gives pslverr=0.
REQ-024 Macro on, RSP_TIMEOUT=8, no response -> pready with pslverr=1 after 8 RSP cycles; a late response is consumed; the following transfer completes normally.
REQ-025 rst_n asserted while in RSP -> all outputs 0 immediately; no pready after release; the next transfer completes normally.
REQ-026 Back-to-back reads to addresses 0x0/0x4 -> exactly two bus requests, with the correct data for each in order.

Source files
------------

// File: rtl/uv_apb_to_bus.sv
// APB completer that turns each APB transfer into one bus request/response pair.
// Optional response timeout with drain of the late response: define UV_APB_TO_BUS_TIMEOUT_EN.
module uv_apb_to_bus #(
  parameter int unsigned ALEN        = 12,
  parameter int unsigned DLEN        = 32,
  parameter int unsigned MLEN        = DLEN / 8,
  parameter int unsigned RSP_TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            apb_psel,
  input  logic            apb_penable,
  input  logic [2:0]      apb_pprot,
  input  logic [ALEN-1:0] apb_paddr,
  input  logic [MLEN-1:0] apb_pstrb,
  input  logic            apb_pwrite,
  input  logic [DLEN-1:0] apb_pwdata,
  output logic [DLEN-1:0] apb_prdata,
  output logic            apb_pready,
  output logic            apb_pslverr,
  output logic            bus_req_vld,
  input  logic            bus_req_rdy,
  output logic            bus_req_read,
  output logic [ALEN-1:0] bus_req_addr,
  output logic [MLEN-1:0] bus_req_mask,
  output logic [DLEN-1:0] bus_req_data,
  input  logic            bus_rsp_vld,
  output logic            bus_rsp_rdy,
  input  logic [1:0]      bus_rsp_excp,
  input  logic [DLEN-1:0] bus_rsp_data
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

  state_e          state_q, state_d;
  logic [ALEN-1:0] addr_q, addr_d;
  logic [MLEN-1:0] mask_q, mask_d;
  logic [DLEN-1:0] data_q, data_d;
  logic            read_q, read_d;
  logic            req_vld_q, req_vld_d;
  logic            rsp_rdy_q, rsp_rdy_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [DLEN-1:0] prdata_q, prdata_d;
  logic            drain_busy;

  logic unused_pprot;
  assign unused_pprot = ^apb_pprot;

`ifdef UV_APB_TO_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(RSP_TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drain_q, drain_d;
  assign drain_busy = drain_q;
`else
  assign drain_busy = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    data_d    = data_q;
    read_d    = read_q;
    req_vld_d = req_vld_q;
    rsp_rdy_d = rsp_rdy_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
    drain_d   = drain_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (apb_psel && !apb_penable && !drain_busy) begin
          addr_d    = apb_paddr;
          read_d    = ~apb_pwrite;
          data_d    = apb_pwdata;
          mask_d    = apb_pwrite ? apb_pstrb : '1;
          req_vld_d = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (bus_req_rdy) begin
          req_vld_d = 1'b0;
          rsp_rdy_d = 1'b1;
          state_d   = StRsp;
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StRsp: begin
        if (bus_rsp_vld) begin
          prdata_d  = read_q ? bus_rsp_data : '0;
          pslverr_d = |bus_rsp_excp;
          rsp_rdy_d = 1'b0;
          pready_d  = 1'b1;
          state_d   = StDone;
        end
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
        else if (cnt_q == CntW'(RSP_TIMEOUT - 1)) begin
          // Give up on the response; rsp_rdy stays high so the late one is drained.
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
          drain_d   = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
    if (drain_q && bus_rsp_vld) begin
      drain_d   = 1'b0;
      rsp_rdy_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      read_q    <= 1'b0;
      req_vld_q <= 1'b0;
      rsp_rdy_q <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
      cnt_q     <= '0;
      drain_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      read_q    <= read_d;
      req_vld_q <= req_vld_d;
      rsp_rdy_q <= rsp_rdy_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
`endif
    end
  end

  assign apb_prdata   = prdata_q;
  assign apb_pready   = pready_q;
  assign apb_pslverr  = pslverr_q;
  assign bus_req_vld  = req_vld_q;
  assign bus_req_read = read_q;
  assign bus_req_addr = addr_q;
  assign bus_req_mask = mask_q;
  assign bus_req_data = data_q;
  assign bus_rsp_rdy  = rsp_rdy_q;

endmodule

// File: tb/tb_uv_apb_to_bus.sv
// Directed bench for uv_apb_to_bus: latency, field stability, errors, reset, back-to-back.
// Timeout/drain vectors run only when UV_APB_TO_BUS_TIMEOUT_EN is defined.
module tb_uv_apb_to_bus;
  localparam int unsigned ALEN = 12;
  localparam int unsigned DLEN = 32;
  localparam int unsigned MLEN = 4;
`ifdef UV_APB_TO_BUS_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 256;
`endif

  logic            clk;
  logic            rst_n;
  logic            apb_psel, apb_penable, apb_pwrite;
  logic [2:0]      apb_pprot;
  logic [ALEN-1:0] apb_paddr;
  logic [MLEN-1:0] apb_pstrb;
  logic [DLEN-1:0] apb_pwdata, apb_prdata;
  logic            apb_pready, apb_pslverr;
  logic            bus_req_vld, bus_req_rdy, bus_req_read;
  logic [ALEN-1:0] bus_req_addr;
  logic [MLEN-1:0] bus_req_mask;
  logic [DLEN-1:0] bus_req_data, bus_rsp_data;
  logic            bus_rsp_vld, bus_rsp_rdy;
  logic [1:0]      bus_rsp_excp;

  int checks;
  int failures;
  int req_cnt;

  uv_apb_to_bus #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN), .RSP_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apb_psel     (apb_psel),
    .apb_penable  (apb_penable),
    .apb_pprot    (apb_pprot),
    .apb_paddr    (apb_paddr),
    .apb_pstrb    (apb_pstrb),
    .apb_pwrite   (apb_pwrite),
    .apb_pwdata   (apb_pwdata),
    .apb_prdata   (apb_prdata),
    .apb_pready   (apb_pready),
    .apb_pslverr  (apb_pslverr),
    .bus_req_vld  (bus_req_vld),
    .bus_req_rdy  (bus_req_rdy),
    .bus_req_read (bus_req_read),
    .bus_req_addr (bus_req_addr),
    .bus_req_mask (bus_req_mask),
    .bus_req_data (bus_req_data),
    .bus_rsp_vld  (bus_rsp_vld),
    .bus_rsp_rdy  (bus_rsp_rdy),
    .bus_rsp_excp (bus_rsp_excp),
    .bus_rsp_data (bus_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial req_cnt = 0;
  always @(posedge clk) if (bus_req_vld && bus_req_rdy) req_cnt <= req_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer. rsp_wait < 0 means the bus never responds.
  task automatic xfer(input logic wr, input logic [ALEN-1:0] addr, input logic [MLEN-1:0] strb,
                      input logic [DLEN-1:0] wdata, input int req_wait, input int rsp_wait,
                      input logic [DLEN-1:0] rdata, input logic [1:0] excp,
                      output logic [DLEN-1:0] prdata, output logic slverr, output int lat);
    int  rq;
    int  rs;
    bit  done;
    rq = 0; rs = 0; done = 0; prdata = '0; slverr = 1'b0;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr; apb_paddr = addr;
    apb_pstrb = strb; apb_pwdata = wdata;
    tick();
    lat = 1;
    apb_penable = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      bus_req_rdy = 1'b0;
      bus_rsp_vld = 1'b0;
      if (apb_pready) begin
        prdata = apb_prdata;
        slverr = apb_pslverr;
        done   = 1;
      end else begin
        if (bus_req_vld) begin
          check_eq("req_addr", bus_req_addr, addr);
          check_eq("req_read", bus_req_read, !wr);
          check_eq("req_mask", bus_req_mask, wr ? strb : 4'hF);
          check_eq("req_data", bus_req_data, wdata);
          bus_req_rdy = (rq >= req_wait);
          rq++;
        end else if (bus_rsp_rdy) begin
          bus_rsp_vld  = (rsp_wait >= 0) && (rs >= rsp_wait);
          bus_rsp_data = rdata;
          bus_rsp_excp = excp;
          rs++;
        end
        tick();
        lat++;
      end
    end
    if (!done) check_eq("pready_bound", 0, 1);
    bus_req_rdy = 1'b0;
    bus_rsp_vld = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    tick();
    check_eq("pready_one_cycle", apb_pready, 0);
  endtask

  logic [DLEN-1:0] rd;
  logic            err;
  int              lat;
  int              base;
  bit              seen;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    apb_psel = 0; apb_penable = 0; apb_pprot = 3'b000; apb_paddr = '0; apb_pstrb = '0;
    apb_pwrite = 0; apb_pwdata = '0;
    bus_req_rdy = 0; bus_rsp_vld = 0; bus_rsp_excp = '0; bus_rsp_data = '0;
    repeat (2) tick();
    check_eq("rst_pready", apb_pready, 0);
    check_eq("rst_vld", bus_req_vld, 0);
    check_eq("rst_rsp_rdy", bus_rsp_rdy, 0);
    check_eq("rst_read", bus_req_read, 0);
    check_eq("rst_prdata", apb_prdata, 0);
    rst_n = 1'b1;
    tick();

    // Zero-wait read
    xfer(1'b0, 12'h010, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 2'b00, rd, err, lat);
    check_eq("rd_lat", lat, 3);
    check_eq("rd_data", rd, 32'hDEADBEEF);
    check_eq("rd_err", err, 0);
    tick();
    check_eq("rd_hold", apb_prdata, 32'hDEADBEEF);

    // Write with 3-cycle request stall; response data must not leak into prdata
    xfer(1'b1, 12'h004, 4'h3, 32'h12345678, 3, 0, 32'hFFFFFFFF, 2'b00, rd, err, lat);
    check_eq("wr_lat", lat, 6);
    check_eq("wr_prdata", rd, 0);
    check_eq("wr_err", err, 0);

    // Error response, then a clean read with a delayed response
    xfer(1'b0, 12'h008, 4'h0, 32'h0, 0, 0, 32'h00001111, 2'b01, rd, err, lat);
    check_eq("ex_err", err, 1);
    check_eq("ex_data", rd, 32'h00001111);
    xfer(1'b0, 12'h00C, 4'h0, 32'h0, 0, 2, 32'h00002222, 2'b00, rd, err, lat);
    check_eq("clean_err", err, 0);
    check_eq("clean_data", rd, 32'h00002222);
    check_eq("clean_lat", lat, 5);

    // Back-to-back reads
    base = req_cnt;
    xfer(1'b0, 12'h000, 4'h0, 32'h0, 0, 0, 32'hA5A50000, 2'b00, rd, err, lat);
    check_eq("b2b0_data", rd, 32'hA5A50000);
    xfer(1'b0, 12'h004, 4'h0, 32'h0, 0, 0, 32'h00005A5A, 2'b00, rd, err, lat);
    check_eq("b2b1_data", rd, 32'h00005A5A);
    check_eq("b2b_req_cnt", req_cnt - base, 2);

    // Reset while waiting for the response
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 12'h020;
    apb_pstrb = 4'h0; apb_pwdata = '0;
    tick();
    apb_penable = 1'b1; bus_req_rdy = 1'b1;
    tick();
    bus_req_rdy = 1'b0;
    check_eq("pre_rst_rsp_rdy", bus_rsp_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rsp_rdy", bus_rsp_rdy, 0);
    check_eq("mid_rst_prdata", apb_prdata, 0);
    check_eq("mid_rst_addr", bus_req_addr, 0);
    check_eq("mid_rst_mask", bus_req_mask, 0);
    check_eq("mid_rst_read", bus_req_read, 0);
    check_eq("mid_rst_pready", apb_pready, 0);
    apb_psel = 1'b0; apb_penable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (apb_pready) seen = 1;
    end
    check_eq("post_rst_no_pready", seen, 0);
    xfer(1'b0, 12'h024, 4'h0, 32'h0, 0, 0, 32'hCAFEF00D, 2'b00, rd, err, lat);
    check_eq("post_rst_data", rd, 32'hCAFEF00D);
    check_eq("post_rst_lat", lat, 3);

`ifdef UV_APB_TO_BUS_TIMEOUT_EN
    // No response: 8 RSP cycles then error; late response is drained
    xfer(1'b0, 12'h030, 4'h0, 32'h0, 0, -1, 32'h0, 2'b00, rd, err, lat);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_data", rd, 0);
    check_eq("tmo_lat", lat, 10);
    check_eq("drain_rsp_rdy", bus_rsp_rdy, 1);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 12'h034;
    tick();
    check_eq("drain_hold_off", bus_req_vld, 0);
    apb_psel = 1'b0;
    bus_rsp_vld = 1'b1; bus_rsp_data = 32'hBAD0BAD0;
    tick();
    bus_rsp_vld = 1'b0;
    check_eq("drain_done", bus_rsp_rdy, 0);
    xfer(1'b0, 12'h038, 4'h0, 32'h0, 0, 0, 32'h0BADF00D, 2'b00, rd, err, lat);
    check_eq("after_tmo_data", rd, 32'h0BADF00D);
    check_eq("after_tmo_err", err, 0);
    check_eq("after_tmo_lat", lat, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
